// File: rtl/walnut_ctrl.sv
// walnut_ctrl: lifecycle controller for one walnut sprite slot.
// Plants the walnut on the lawn grid, tracks its health under zombie bites,
// produces idle eye blinks while alive and a flashing death animation, and
// presents registered position/blink/enable signals to the sprite renderer.
module walnut_ctrl #(
  parameter logic [6:0] HEALTH_MAX   = 7'd40,
  parameter logic [2:0] ROWS         = 3'd5,
  parameter logic [3:0] COLS         = 4'd9,
  parameter logic [9:0] ORIGIN_H     = 10'd60,
  parameter logic [9:0] ORIGIN_V     = 10'd80,
  parameter logic [9:0] CELL_W       = 10'd64,
  parameter logic [9:0] CELL_H       = 10'd80,
  parameter logic [7:0] BLINK_PERIOD = 8'd180,
  parameter logic [7:0] BLINK_LEN    = 8'd8,
  parameter logic [5:0] DEATH_FRAMES = 6'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       place,
  input  logic [2:0] place_row,
  input  logic [3:0] place_col,
  input  logic       bite,
  output logic [9:0] wVPos,
  output logic [9:0] wHPos,
  output logic       blink,
  output logic       enable,
  output logic [6:0] health,
  output logic       occupied,
  output logic       dead
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIVE = 2'd1,
    S_DYING = 2'd2
  } state_t;

  localparam logic [7:0] BLINK_START = BLINK_PERIOD - BLINK_LEN;
  localparam logic [5:0] DEATH_LAST  = DEATH_FRAMES - 6'd1;

  state_t     r_state;
  logic [9:0] r_vpos;
  logic [9:0] r_hpos;
  logic       r_blink;
  logic       r_enable;
  logic [6:0] r_health;
  logic       r_occupied;
  logic       r_dead;
  logic [7:0] r_frame_cnt;
  logic [5:0] r_death_cnt;

  logic       w_place_ok;
  logic [7:0] w_frame_nxt;
  logic [5:0] w_death_nxt;
  logic [9:0] w_hpos_new;
  logic [9:0] w_vpos_new;

  // Next-value helpers: place validity, grid-to-pixel mapping, counter increments
  always_comb begin
    w_place_ok  = place && (place_row < ROWS) && (place_col < COLS);
    w_hpos_new  = ORIGIN_H + (10'(place_col) * CELL_W);
    w_vpos_new  = ORIGIN_V + (10'(place_row) * CELL_H);
    w_frame_nxt = r_frame_cnt;
    if (frame_tick) begin
      w_frame_nxt = (r_frame_cnt == BLINK_PERIOD - 8'd1) ? 8'd0 : r_frame_cnt + 8'd1;
    end
    w_death_nxt = r_death_cnt + 6'd1;
  end

  // Lifecycle FSM; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vpos      <= 10'd0;
      r_hpos      <= 10'd0;
      r_blink     <= 1'b0;
      r_enable    <= 1'b0;
      r_health    <= 7'd0;
      r_occupied  <= 1'b0;
      r_dead      <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_death_cnt <= 6'd0;
    end else begin
      r_dead <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_enable   <= 1'b0;
          r_blink    <= 1'b0;
          r_occupied <= 1'b0;
          // a tick arriving with place is not counted: counter restarts at 0
          if (w_place_ok) begin
            r_state     <= S_ALIVE;
            r_hpos      <= w_hpos_new;
            r_vpos      <= w_vpos_new;
            r_health    <= HEALTH_MAX;
            r_frame_cnt <= 8'd0;
            r_enable    <= 1'b1;
            r_occupied  <= 1'b1;
          end
        end

        S_ALIVE: begin
          r_enable    <= 1'b1;
          r_occupied  <= 1'b1;
          r_frame_cnt <= w_frame_nxt;
          r_blink     <= (w_frame_nxt >= BLINK_START);
          // place is ignored here; bite wins over a simultaneous place
          if (bite) begin
            r_health <= r_health - 7'd1;
            if (r_health == 7'd1) begin
              r_dead      <= 1'b1;
              r_state     <= S_DYING;
              r_death_cnt <= 6'd0;
              r_blink     <= 1'b1;
            end
          end
        end

        S_DYING: begin
          r_blink <= 1'b1;
          if (frame_tick) begin
            if (r_death_cnt == DEATH_LAST) begin
              r_state     <= S_IDLE;
              r_death_cnt <= 6'd0;
              r_enable    <= 1'b0;
              r_occupied  <= 1'b0;
              r_blink     <= 1'b0;
            end else begin
              r_death_cnt <= w_death_nxt;
              // flash: visible for 4 frames, hidden for 4 frames
              r_enable    <= ~w_death_nxt[2];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wVPos    = r_vpos;
  assign wHPos    = r_hpos;
  assign blink    = r_blink;
  assign enable   = r_enable;
  assign health   = r_health;
  assign occupied = r_occupied;
  assign dead     = r_dead;

endmodule
